// File: rtl/bus_pkg.sv
// Shared types and helpers for the D-bus crossbar arbiter.
// Contents:
//   ttype_t      - transfer direction (READ/WRITE)
//   tsize_t      - transfer size (BYTE/HALFWORD/WORD)
//   xbar_state_t - crossbar FSM states
//   is_aligned   - natural-alignment check on the low address bits
package bus_pkg;

   typedef enum logic {READ = 1'b0, WRITE = 1'b1} ttype_t;

   typedef enum logic [1:0] {BYTE = 2'd0, HALFWORD = 2'd1, WORD = 2'd2} tsize_t;

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} xbar_state_t;

   // Only the two lowest address bits matter for alignment. The unused
   // size encoding is treated as misaligned so it gets an error response
   // instead of reaching a slave.
   function automatic logic is_aligned(input logic [1:0] addrLo, input tsize_t tsize);
      case (tsize)
         BYTE:     return 1'b1;
         HALFWORD: return (addrLo[0] == 1'b0);
         WORD:     return (addrLo == 2'b00);
         default:  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   i_req [N]  - request vector
//   i_ptr [IW] - index with highest priority this cycle
//   o_gnt [N]  - one-hot grant
//   o_idx [IW] - index of the granted requester
//   o_any      - at least one request present
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   // Walk the requesters starting at the pointer and wrapping around;
   // the first one found wins.
   always_comb begin
      int j;
      j     = 0;
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = (int'(i_ptr) + k) % N;
         if (!o_any && i_req[j]) begin
            o_any    = 1'b1;
            o_gnt[j] = 1'b1;
            o_idx    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/dbus_xbar_arb.sv
// Shared D-bus fabric: N_M masters to N_S memory-mapped slaves, one
// transaction in flight at a time. Round-robin master selection,
// table-driven address decode, alignment check, per-transaction timeout
// and error response.
// Ports:
//   clk, rst                        - clock, async active-high reset
//   m_bstart/m_addr/m_ttype/
//   m_tsize/m_wdata                 - per-master request
//   m_bdone/m_berr                  - per-master completion pulse and error
//   m_rdata                         - shared read data, valid with m_bdone
//   s_ss/s_bstart                   - one-hot slave select and start pulse
//   s_addr/s_ttype/s_tsize/s_wdata  - registered request fields
//   s_bdone/s_rdata                 - per-slave completion and read data
module dbus_xbar_arb
   import bus_pkg::*;
#(
   parameter int                       N_M     = 2,
   parameter int                       N_S     = 4,
   parameter int                       AW      = 32,
   parameter int                       DW      = 32,
   parameter logic [N_S-1:0][AW-1:0]   S_BASE  = '0,
   parameter logic [N_S-1:0][AW-1:0]   S_MASK  = '0,
   parameter int                       TIMEOUT = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_M-1:0]         m_bstart,
   input  logic [N_M-1:0][AW-1:0] m_addr,
   input  ttype_t [N_M-1:0]       m_ttype,
   input  tsize_t [N_M-1:0]       m_tsize,
   input  logic [N_M-1:0][DW-1:0] m_wdata,
   output logic [N_M-1:0]         m_bdone,
   output logic [N_M-1:0]         m_berr,
   output logic [DW-1:0]          m_rdata,
   output logic [N_S-1:0]         s_ss,
   output logic                   s_bstart,
   output logic [AW-1:0]          s_addr,
   output ttype_t                 s_ttype,
   output tsize_t                 s_tsize,
   output logic [DW-1:0]          s_wdata,
   input  logic [N_S-1:0]         s_bdone,
   input  logic [N_S-1:0][DW-1:0] s_rdata
);

   localparam int MIW = (N_M > 1) ? $clog2(N_M) : 1;
   localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   xbar_state_t    r_state;
   logic [N_M-1:0] r_pending;
   logic [MIW-1:0] r_rrPtr;
   logic [MIW-1:0] r_winIdx;
   logic [TW-1:0]  r_timer;
   logic           r_tmo;
   logic           r_err;

   logic [N_M-1:0] w_cand;
   logic [N_M-1:0] w_gnt;
   logic [MIW-1:0] w_gntIdx;
   logic           w_any;
   logic [AW-1:0]  w_reqAddr;
   logic           w_hit;
   logic [N_S-1:0] w_hitOh;
   logic           w_aligned;
   logic [N_M-1:0] w_clr;
   logic [N_M-1:0] w_pendNext;
   logic           w_selDone;
   logic [DW-1:0]  w_selData;
   logic [MIW-1:0] w_ptrNext;

   // Masters already waiting plus fresh pulses this cycle, so an idle
   // fabric can grant a request in the same cycle it arrives.
   assign w_cand = r_pending | m_bstart;

   rr_arbiter #(.N(N_M), .IW(MIW)) u_arb (
      .i_req (w_cand),
      .i_ptr (r_rrPtr),
      .o_gnt (w_gnt),
      .o_idx (w_gntIdx),
      .o_any (w_any)
   );

   assign w_reqAddr = m_addr[w_gntIdx];
   assign w_aligned = is_aligned(w_reqAddr[1:0], m_tsize[w_gntIdx]);

   // Address decode against the base/mask table. Regions may overlap, so
   // the first (lowest-index) match is taken.
   always_comb begin
      w_hit   = 1'b0;
      w_hitOh = '0;
      for (int i = 0; i < N_S; i++) begin
         if (!w_hit && ((w_reqAddr & S_MASK[i]) == S_BASE[i])) begin
            w_hit      = 1'b1;
            w_hitOh[i] = 1'b1;
         end
      end
   end

   // Only the selected slave's completion and data are looked at; strobes
   // from any other slave are ignored.
   always_comb begin
      w_selData = '0;
      for (int i = 0; i < N_S; i++) begin
         if (s_ss[i]) w_selData = s_rdata[i];
      end
   end
   assign w_selDone = |(s_bdone & s_ss);

   // A master's pending bit clears in its response cycle. A new pulse is
   // accepted when nothing is pending for that master, or when the
   // pending one is finishing right now; otherwise the pulse is dropped.
   assign w_clr      = (r_state == RESP) ? (N_M'(1) << r_winIdx) : '0;
   assign w_pendNext = (r_pending & ~w_clr) | (m_bstart & (~r_pending | w_clr));

   assign w_ptrNext = (r_winIdx == MIW'(N_M - 1)) ? '0 : r_winIdx + 1'b1;

   // Main FSM with all slave- and master-facing outputs registered.
   // A decode or alignment error still passes through BUSY for one cycle
   // (with no slave select or start) so error responses arrive two cycles
   // after the request. The timeout compare is registered into r_tmo, so
   // the error fires one cycle after the timer reaches TIMEOUT-1, and a
   // slave completion in that same cycle still wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_rrPtr   <= '0;
         r_winIdx  <= '0;
         r_timer   <= '0;
         r_tmo     <= 1'b0;
         r_err     <= 1'b0;
         s_ss      <= '0;
         s_bstart  <= 1'b0;
         s_addr    <= '0;
         s_ttype   <= READ;
         s_tsize   <= BYTE;
         s_wdata   <= '0;
         m_bdone   <= '0;
         m_berr    <= '0;
         m_rdata   <= '0;
      end else begin
         r_pending <= w_pendNext;
         s_bstart  <= 1'b0;
         m_bdone   <= '0;
         m_berr    <= '0;
         m_rdata   <= '0;
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_winIdx <= w_gntIdx;
                  r_timer  <= '0;
                  r_tmo    <= 1'b0;
                  if (w_hit && w_aligned) begin
                     s_ss     <= w_hitOh;
                     s_bstart <= 1'b1;
                     s_addr   <= w_reqAddr;
                     s_ttype  <= m_ttype[w_gntIdx];
                     s_tsize  <= m_tsize[w_gntIdx];
                     s_wdata  <= m_wdata[w_gntIdx];
                     r_err    <= 1'b0;
                  end else begin
                     r_err    <= 1'b1;
                  end
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (r_err) begin
                  m_bdone[r_winIdx] <= 1'b1;
                  m_berr[r_winIdx]  <= 1'b1;
                  r_state           <= RESP;
               end else if (w_selDone) begin
                  m_bdone[r_winIdx] <= 1'b1;
                  if (s_ttype == READ) m_rdata <= w_selData;
                  s_ss              <= '0;
                  r_state           <= RESP;
               end else if (r_tmo) begin
                  m_bdone[r_winIdx] <= 1'b1;
                  m_berr[r_winIdx]  <= 1'b1;
                  s_ss              <= '0;
                  r_state           <= RESP;
               end else begin
                  r_timer <= r_timer + 1'b1;
                  r_tmo   <= (TIMEOUT != 0) && (r_timer == TW'(TIMEOUT - 1));
               end
            end
            RESP: begin
               r_rrPtr <= w_ptrNext;
               r_timer <= '0;
               r_tmo   <= 1'b0;
               r_err   <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // A master must not pulse again while its previous request is pending.
   a_noReissue: assert property (@(posedge clk) disable iff (rst)
      (m_bstart & r_pending & ~w_clr) == '0);

   // The arbiter must never grant more than one master.
   a_gntOnehot: assert property (@(posedge clk) disable iff (rst)
      w_any |-> $onehot(w_gnt));

endmodule

// File: tb/tb_dbus_xbar_arb.sv
// Directed self-checking bench for dbus_xbar_arb (2 masters, 4 slaves,
// TIMEOUT=8). Slave map: 0 mem 0x2xxx_xxxx, 1 gpio 0x4000_0xxx,
// 2 clint 0x0200_xxxx, 3 plic 0x0C00_0000-0x0FFF_FFFF.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dbus_xbar_arb;
   import bus_pkg::*;

   logic                clk;
   logic                rst;
   logic [1:0]          m_bstart;
   logic [1:0][31:0]    m_addr;
   ttype_t [1:0]        m_ttype;
   tsize_t [1:0]        m_tsize;
   logic [1:0][31:0]    m_wdata;
   logic [1:0]          m_bdone;
   logic [1:0]          m_berr;
   logic [31:0]         m_rdata;
   logic [3:0]          s_ss;
   logic                s_bstart;
   logic [31:0]         s_addr;
   ttype_t              s_ttype;
   tsize_t              s_tsize;
   logic [31:0]         s_wdata;
   logic [3:0]          s_bdone;
   logic [3:0][31:0]    s_rdata;

   int checks;
   int failures;

   dbus_xbar_arb #(
      .N_M     (2),
      .N_S     (4),
      .AW      (32),
      .DW      (32),
      .S_BASE  ({32'h0C00_0000, 32'h0200_0000, 32'h4000_0000, 32'h2000_0000}),
      .S_MASK  ({32'hFC00_0000, 32'hFFFF_0000, 32'hFFFF_F000, 32'hF000_0000}),
      .TIMEOUT (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .m_bstart (m_bstart),
      .m_addr   (m_addr),
      .m_ttype  (m_ttype),
      .m_tsize  (m_tsize),
      .m_wdata  (m_wdata),
      .m_bdone  (m_bdone),
      .m_berr   (m_berr),
      .m_rdata  (m_rdata),
      .s_ss     (s_ss),
      .s_bstart (s_bstart),
      .s_addr   (s_addr),
      .s_ttype  (s_ttype),
      .s_tsize  (s_tsize),
      .s_wdata  (s_wdata),
      .s_bdone  (s_bdone),
      .s_rdata  (s_rdata)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   // Set up one master's request fields and raise its start pulse.
   task automatic applyStimulus(input int m, input logic [31:0] addr, input ttype_t tt,
                                input tsize_t ts, input logic [31:0] wd);
      m_bstart[m] = 1'b1;
      m_addr[m]   = addr;
      m_ttype[m]  = tt;
      m_tsize[m]  = ts;
      m_wdata[m]  = wd;
   endtask

   // Single-cycle completion from one slave with its read data.
   task automatic slavePulse(input int s, input logic [31:0] d);
      s_bdone    = '0;
      s_bdone[s] = 1'b1;
      s_rdata[s] = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++; if (s_ss !== 4'b0000) begin failures++; $display("[TB] FAIL rst_s_ss got=%0h exp=0", s_ss); end
      checks++; if (s_bstart !== 1'b0) begin failures++; $display("[TB] FAIL rst_s_bstart got=%0h exp=0", s_bstart); end
      checks++; if (m_bdone !== 2'b00) begin failures++; $display("[TB] FAIL rst_m_bdone got=%0h exp=0", m_bdone); end
      checks++; if (m_berr !== 2'b00) begin failures++; $display("[TB] FAIL rst_m_berr got=%0h exp=0", m_berr); end
      checks++; if (m_rdata !== 32'h0) begin failures++; $display("[TB] FAIL rst_m_rdata got=%0h exp=0", m_rdata); end
      checks++; if (s_addr !== 32'h0) begin failures++; $display("[TB] FAIL rst_s_addr got=%0h exp=0", s_addr); end
      rst = 1'b0;
   endtask

   // WORD READ to mem, slave answers two cycles after its start pulse.
   task automatic test_single_read();
      applyStimulus(0, 32'h2000_0010, READ, WORD, 32'h0);              // T
      tick(); m_bstart = '0;                                            // T+1
      checks++; if (s_bstart !== 1'b1) begin failures++; $display("[TB] FAIL t1_s_bstart got=%0h exp=1", s_bstart); end
      checks++; if (s_ss !== 4'b0001) begin failures++; $display("[TB] FAIL t1_s_ss got=%0h exp=1", s_ss); end
      checks++; if (s_addr !== 32'h2000_0010) begin failures++; $display("[TB] FAIL t1_s_addr got=%0h exp=20000010", s_addr); end
      tick();                                                           // T+2
      checks++; if (s_bstart !== 1'b0) begin failures++; $display("[TB] FAIL t1_s_bstart_drop got=%0h exp=0", s_bstart); end
      tick(); slavePulse(0, 32'hDEAD_BEEF);                             // T+3
      checks++; if (m_bdone !== 2'b00) begin failures++; $display("[TB] FAIL t1_early_bdone got=%0h exp=0", m_bdone); end
      tick(); s_bdone = '0;                                             // T+4
      checks++; if (m_bdone !== 2'b01) begin failures++; $display("[TB] FAIL t1_m_bdone got=%0h exp=1", m_bdone); end
      checks++; if (m_berr !== 2'b00) begin failures++; $display("[TB] FAIL t1_m_berr got=%0h exp=0", m_berr); end
      checks++; if (m_rdata !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL t1_m_rdata got=%0h exp=deadbeef", m_rdata); end
      checks++; if (s_ss !== 4'b0000) begin failures++; $display("[TB] FAIL t1_s_ss_drop got=%0h exp=0", s_ss); end
      tick();                                                           // T+5
      checks++; if (m_bdone !== 2'b00) begin failures++; $display("[TB] FAIL t1_bdone_pulse got=%0h exp=0", m_bdone); end
   endtask

   // Simultaneous requests with pointer at 0, then a single m0 request
   // moves the pointer to 1 so the next simultaneous pair serves m1 first.
   task automatic test_round_robin();
      rst = 1'b1; tick(); rst = 1'b0;
      applyStimulus(0, 32'h2000_0100, READ, WORD, 32'h0);
      applyStimulus(1, 32'h4000_0008, READ, WORD, 32'h0);              // T
      tick(); m_bstart = '0;                                            // T+1
      checks++; if (s_ss !== 4'b0001) begin failures++; $display("[TB] FAIL t2_first_m0 got=%0h exp=1", s_ss); end
      slavePulse(0, 32'h1111_1111);
      tick(); s_bdone = '0;                                             // T+2
      checks++; if (m_bdone !== 2'b01) begin failures++; $display("[TB] FAIL t2_done_m0 got=%0h exp=1", m_bdone); end
      checks++; if (m_rdata !== 32'h1111_1111) begin failures++; $display("[TB] FAIL t2_rdata_m0 got=%0h exp=11111111", m_rdata); end
      tick();                                                           // T+3 idle
      checks++; if (s_bstart !== 1'b0) begin failures++; $display("[TB] FAIL t2_idle_gap got=%0h exp=0", s_bstart); end
      tick();                                                           // T+4
      checks++; if (s_ss !== 4'b0010) begin failures++; $display("[TB] FAIL t2_second_m1 got=%0h exp=2", s_ss); end
      checks++; if (s_addr !== 32'h4000_0008) begin failures++; $display("[TB] FAIL t2_addr_m1 got=%0h exp=40000008", s_addr); end
      slavePulse(1, 32'h2222_2222);
      tick(); s_bdone = '0;                                             // T+5
      checks++; if (m_bdone !== 2'b10) begin failures++; $display("[TB] FAIL t2_done_m1 got=%0h exp=2", m_bdone); end
      checks++; if (m_rdata !== 32'h2222_2222) begin failures++; $display("[TB] FAIL t2_rdata_m1 got=%0h exp=22222222", m_rdata); end
      tick();
      applyStimulus(0, 32'h2000_0200, READ, WORD, 32'h0);
      tick(); m_bstart = '0; slavePulse(0, 32'h3333_3333);
      tick(); s_bdone = '0;
      checks++; if (m_bdone !== 2'b01) begin failures++; $display("[TB] FAIL t2_single_m0 got=%0h exp=1", m_bdone); end
      tick();
      applyStimulus(0, 32'h2000_0300, READ, WORD, 32'h0);
      applyStimulus(1, 32'h4000_000C, READ, WORD, 32'h0);              // Y
      tick(); m_bstart = '0;                                            // Y+1
      checks++; if (s_ss !== 4'b0010) begin failures++; $display("[TB] FAIL t2_pair2_m1_first got=%0h exp=2", s_ss); end
      slavePulse(1, 32'h4444_4444);
      tick(); s_bdone = '0;                                             // Y+2
      checks++; if (m_bdone !== 2'b10) begin failures++; $display("[TB] FAIL t2_pair2_done_m1 got=%0h exp=2", m_bdone); end
      tick();                                                           // Y+3
      tick();                                                           // Y+4
      checks++; if (s_ss !== 4'b0001) begin failures++; $display("[TB] FAIL t2_pair2_m0_second got=%0h exp=1", s_ss); end
      slavePulse(0, 32'h5555_5555);
      tick(); s_bdone = '0;                                             // Y+5
      checks++; if (m_rdata !== 32'h5555_5555) begin failures++; $display("[TB] FAIL t2_pair2_rdata_m0 got=%0h exp=55555555", m_rdata); end
      tick();
   endtask

   // Misaligned WORD, misaligned HALFWORD, unmapped address.
   task automatic test_errors();
      logic [31:0] addrs [3];
      tsize_t      sizes [3];
      int          mst   [3];
      logic [1:0]  expMask;
      addrs = '{32'h2000_0002, 32'h2000_0001, 32'hF000_0000};
      sizes = '{WORD, HALFWORD, WORD};
      mst   = '{0, 0, 1};
      for (int v = 0; v < 3; v++) begin
         expMask = 2'b01 << mst[v];
         applyStimulus(mst[v], addrs[v], (v == 2) ? WRITE : READ, sizes[v], 32'hA5A5_A5A5);
         tick(); m_bstart = '0;
         checks++; if ((s_ss !== 4'b0000) || (s_bstart !== 1'b0)) begin failures++; $display("[TB] FAIL t3_no_slave_%0d ss=%0h bstart=%0h exp=0/0", v, s_ss, s_bstart); end
         checks++; if (m_bdone !== 2'b00) begin failures++; $display("[TB] FAIL t3_early_%0d got=%0h exp=0", v, m_bdone); end
         tick();
         checks++; if (m_bdone !== expMask) begin failures++; $display("[TB] FAIL t3_bdone_%0d got=%0h exp=%0h", v, m_bdone, expMask); end
         checks++; if (m_berr !== expMask) begin failures++; $display("[TB] FAIL t3_berr_%0d got=%0h exp=%0h", v, m_berr, expMask); end
         checks++; if ((m_rdata !== 32'h0) || (s_ss !== 4'b0000)) begin failures++; $display("[TB] FAIL t3_rdata_ss_%0d rdata=%0h ss=%0h exp=0/0", v, m_rdata, s_ss); end
         tick();
      end
   endtask

   // Silent slave times out 9 cycles after the start pulse; a stray
   // completion from an unselected slave is ignored. Then a slave
   // completion landing in the timeout cycle must win.
   task automatic test_timeout();
      applyStimulus(0, 32'h2000_0400, READ, WORD, 32'h0);              // T
      tick(); m_bstart = '0;                                            // T+1
      checks++; if (s_bstart !== 1'b1) begin failures++; $display("[TB] FAIL t4_s_bstart got=%0h exp=1", s_bstart); end
      for (int k = 2; k <= 9; k++) begin
         tick();
         s_bdone = (k == 3) ? 4'b0100 : 4'b0000;
         checks++; if ((m_bdone !== 2'b00) || (s_ss !== 4'b0001)) begin failures++; $display("[TB] FAIL t4_wait_%0d bdone=%0h ss=%0h exp=0/1", k, m_bdone, s_ss); end
      end
      tick();                                                           // T+10
      checks++; if (m_bdone !== 2'b01) begin failures++; $display("[TB] FAIL t4_tmo_bdone got=%0h exp=1", m_bdone); end
      checks++; if (m_berr !== 2'b01) begin failures++; $display("[TB] FAIL t4_tmo_berr got=%0h exp=1", m_berr); end
      checks++; if ((s_ss !== 4'b0000) || (m_rdata !== 32'h0)) begin failures++; $display("[TB] FAIL t4_tmo_ss_rdata ss=%0h rdata=%0h exp=0/0", s_ss, m_rdata); end
      tick();
      applyStimulus(1, 32'h2000_0500, READ, WORD, 32'h0);
      tick(); m_bstart = '0;
      for (int k = 2; k <= 9; k++) begin
         tick();
         if (k == 9) slavePulse(0, 32'hCAFE_F00D);
      end
      tick(); s_bdone = '0;
      checks++; if (m_bdone !== 2'b10) begin failures++; $display("[TB] FAIL t4_race_bdone got=%0h exp=2", m_bdone); end
      checks++; if (m_berr !== 2'b00) begin failures++; $display("[TB] FAIL t4_race_berr got=%0h exp=0", m_berr); end
      checks++; if (m_rdata !== 32'hCAFE_F00D) begin failures++; $display("[TB] FAIL t4_race_rdata got=%0h exp=cafef00d", m_rdata); end
      tick();
   endtask

   // Reset during BUSY drops everything immediately and issues no done.
   task automatic test_reset_mid();
      applyStimulus(0, 32'h4000_0010, READ, WORD, 32'h0);
      tick(); m_bstart = '0;
      checks++; if (s_ss !== 4'b0010) begin failures++; $display("[TB] FAIL t5_busy_ss got=%0h exp=2", s_ss); end
      tick();
      #1 rst = 1'b1;
      #1;
      checks++; if ((s_ss !== 4'b0000) || (s_bstart !== 1'b0)) begin failures++; $display("[TB] FAIL t5_async_clear ss=%0h bstart=%0h exp=0/0", s_ss, s_bstart); end
      tick();
      tick(); rst = 1'b0;
      tick();
      checks++; if (m_bdone !== 2'b00) begin failures++; $display("[TB] FAIL t5_no_bdone got=%0h exp=0", m_bdone); end
      applyStimulus(0, 32'h2000_0020, READ, WORD, 32'h0);
      tick(); m_bstart = '0; slavePulse(0, 32'h0BAD_F00D);
      tick(); s_bdone = '0;
      checks++; if ((m_bdone !== 2'b01) || (m_rdata !== 32'h0BAD_F00D)) begin failures++; $display("[TB] FAIL t5_after_rst bdone=%0h rdata=%0h exp=1/badf00d", m_bdone, m_rdata); end
      tick();
   endtask

   // BYTE WRITE to gpio with next-cycle completion; a new request issued
   // in the same cycle as the done pulse is accepted.
   task automatic test_back_to_back();
      applyStimulus(0, 32'h4000_0004, WRITE, BYTE, 32'h0000_0055);     // T
      tick(); m_bstart = '0;                                            // T+1
      checks++; if (s_ss !== 4'b0010) begin failures++; $display("[TB] FAIL t6_s_ss got=%0h exp=2", s_ss); end
      checks++; if (s_wdata !== 32'h0000_0055) begin failures++; $display("[TB] FAIL t6_s_wdata got=%0h exp=55", s_wdata); end
      checks++; if ((s_tsize !== BYTE) || (s_ttype !== WRITE)) begin failures++; $display("[TB] FAIL t6_size_type tsize=%0h ttype=%0h exp=0/1", s_tsize, s_ttype); end
      slavePulse(1, 32'hFFFF_FFFF);
      tick(); s_bdone = '0;                                             // T+2
      checks++; if (m_bdone !== 2'b01) begin failures++; $display("[TB] FAIL t6_m_bdone got=%0h exp=1", m_bdone); end
      checks++; if ((m_rdata !== 32'h0) || (m_berr !== 2'b00)) begin failures++; $display("[TB] FAIL t6_rdata_berr rdata=%0h berr=%0h exp=0/0", m_rdata, m_berr); end
      applyStimulus(0, 32'h2000_0040, READ, WORD, 32'h0);
      tick(); m_bstart = '0;                                            // T+3
      checks++; if (s_bstart !== 1'b0) begin failures++; $display("[TB] FAIL t6_idle_gap got=%0h exp=0", s_bstart); end
      tick();                                                           // T+4
      checks++; if ((s_bstart !== 1'b1) || (s_addr !== 32'h2000_0040)) begin failures++; $display("[TB] FAIL t6_reissue bstart=%0h addr=%0h exp=1/20000040", s_bstart, s_addr); end
      slavePulse(0, 32'h1234_5678);
      tick(); s_bdone = '0;                                             // T+5
      checks++; if ((m_bdone !== 2'b01) || (m_rdata !== 32'h1234_5678)) begin failures++; $display("[TB] FAIL t6_reissue_done bdone=%0h rdata=%0h exp=1/12345678", m_bdone, m_rdata); end
      tick();
   endtask

   // Run every scenario in order, then report.
   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      m_bstart = '0;
      m_addr   = '0;
      m_ttype  = '{READ, READ};
      m_tsize  = '{WORD, WORD};
      m_wdata  = '0;
      s_bdone  = '0;
      s_rdata  = '0;
      test_reset();
      test_single_read();
      test_round_robin();
      test_errors();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
